// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing generator and DAC-side pixel output stage.
//            Optional macro VGA_RGB_REG_EN registers all DAC-side outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       frame_start
);

  // Totals must fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] c_H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic       pix_q, pix_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       frame_start_q, frame_start_d;

  logic       w_visible;
  logic       w_hs_raw;
  logic       w_vs_raw;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_q         <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pix_q         <= pix_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  // pix_q doubles as the pixel enable: counters step on edges where it is high.
  always_comb begin
    pix_d         = ~pix_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (pix_q) begin
      if (h_cnt_q == c_H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == c_V_LAST) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  assign w_visible = (h_cnt_q < c_H_VIS) && (v_cnt_q < c_V_VIS);
  assign w_hs_raw  = !((h_cnt_q >= c_HS_START) && (h_cnt_q <= c_HS_END));
  assign w_vs_raw  = !((v_cnt_q >= c_VS_START) && (v_cnt_q <= c_VS_END));

  assign DrawX       = h_cnt_q;
  assign DrawY       = v_cnt_q;
  assign VGA_CLK     = pix_q;
  assign VGA_SYNC_N  = 1'b0;
  assign frame_start = frame_start_q;

`ifdef VGA_RGB_REG_EN
  logic       hs_q, vs_q, blank_q;
  logic [7:0] r_q, g_q, b_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else if (pix_q) begin
      hs_q    <= w_hs_raw;
      vs_q    <= w_vs_raw;
      blank_q <= w_visible;
      r_q     <= w_visible ? Red   : 8'h00;
      g_q     <= w_visible ? Green : 8'h00;
      b_q     <= w_visible ? Blue  : 8'h00;
    end
  end

  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
`else
  // Counters sit at (0,0) during reset, which is visible; hold the DAC dark.
  logic w_vis_out;
  assign w_vis_out   = w_visible & ~Reset;

  assign VGA_HS      = w_hs_raw;
  assign VGA_VS      = w_vs_raw;
  assign VGA_BLANK_N = w_vis_out;
  assign VGA_R       = w_vis_out ? Red   : 8'h00;
  assign VGA_G       = w_vis_out ? Green : 8'h00;
  assign VGA_B       = w_vis_out ? Blue  : 8'h00;
`endif

endmodule

`default_nettype wire
